// File: rtl/mem_stage_if.sv
// Bus between the memory-stage controller and its surroundings: the EX/MEM
// latch fields coming in, the data-cache request/response and the MEM/WB
// payload going out.
//
// Request handshake: a request (dmemREN or dmemWEN) is a combinational
// "valid". It stays asserted with a stable address and store data until
// the cache answers with dhit=1, which acts as "ready". The transfer
// completes in the cycle where both are high. dhit with no request
// asserted carries no meaning.
interface mem_stage_if;
    logic        ex_valid;
    logic        ex_dREN;
    logic        ex_dWEN;
    logic [31:0] ex_aluresult;
    logic [31:0] ex_rdat2;
    logic [4:0]  ex_wsel;
    logic        ex_regWEN;
    logic        ex_halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_regWEN;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        wb_halt;

    // Controller side.
    modport master (
        input  ex_valid, ex_dREN, ex_dWEN, ex_aluresult, ex_rdat2,
               ex_wsel, ex_regWEN, ex_halt, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_valid, wb_regWEN, wb_wsel, wb_wdat, wb_halt
    );

    // Pipeline/cache side.
    modport slave (
        output ex_valid, ex_dREN, ex_dWEN, ex_aluresult, ex_rdat2,
               ex_wsel, ex_regWEN, ex_halt, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_valid, wb_regWEN, wb_wsel, wb_wdat, wb_halt
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues the data-cache request for the
// instruction in the EX/MEM latch, stalls the front of the pipe until the
// cache answers, registers the MEM/WB payload and parks in a sticky HALTED
// state once a HALT has been captured.
module mem_stage_ctrl #(
    parameter int WAIT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    mem_stage_if.master       bus,
    output logic [WAIT_W-1:0] wait_cycles,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_regwen_q, wb_regwen_d;
    logic [4:0]        wb_wsel_q, wb_wsel_d;
    logic [31:0]       wb_wdat_q, wb_wdat_d;
    logic              wb_halt_q, wb_halt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic halted;
    logic memop;
    logic is_load;
    logic stall;

    // Request decode. RST gates the request so it drops asynchronously
    // when reset hits in the middle of an access; a load wins over an
    // (illegal) simultaneous store.
    always_comb begin
        halted  = (state_q == HALTED);
        memop   = bus.ex_valid & (bus.ex_dREN | bus.ex_dWEN) & ~bus.ex_halt
                  & ~halted & ~RST;
        is_load = memop & bus.ex_dREN;
        stall   = halted | (memop & ~bus.dhit);
    end

    assign bus.dmemREN   = is_load;
    assign bus.dmemWEN   = memop & ~bus.ex_dREN;
    assign bus.dmemaddr  = bus.ex_aluresult;
    assign bus.dmemstore = bus.ex_rdat2;
    assign bus.mem_stall = stall;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_regWEN = wb_regwen_q;
    assign bus.wb_wsel   = wb_wsel_q;
    assign bus.wb_wdat   = wb_wdat_q;
    assign bus.wb_halt   = wb_halt_q;
    assign wait_cycles   = wait_q;
    assign dbg_state     = state_q;

    // Next state, MEM/WB capture and stall counting.
    always_comb begin
        state_d     = state_q;
        wb_valid_d  = wb_valid_q;
        wb_regwen_d = wb_regwen_q;
        wb_wsel_d   = wb_wsel_q;
        wb_wdat_d   = wb_wdat_q;
        wb_halt_d   = wb_halt_q;
        wait_d      = wait_q;

        case (state_q)
            IDLE, ACCESS: begin
                if (stall) begin
                    state_d = ACCESS;
                end else if (bus.ex_valid & bus.ex_halt) begin
                    state_d = HALTED;
                end else begin
                    state_d = IDLE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase

        if (stall) begin
            // A stalled edge pushes a bubble into WB; data fields hold.
            wb_valid_d  = 1'b0;
            wb_regwen_d = 1'b0;
        end else begin
            wb_valid_d  = bus.ex_valid;
            wb_regwen_d = bus.ex_valid & bus.ex_regWEN;
            wb_wsel_d   = bus.ex_wsel;
            wb_wdat_d   = is_load ? bus.dmemload : bus.ex_aluresult;
            wb_halt_d   = wb_halt_q | (bus.ex_valid & bus.ex_halt);
        end

        if (stall && !halted && (wait_q != {WAIT_W{1'b1}})) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // State and MEM/WB registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            wb_valid_q  <= 1'b0;
            wb_regwen_q <= 1'b0;
            wb_wsel_q   <= 5'd0;
            wb_wdat_q   <= 32'd0;
            wb_halt_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_regwen_q <= wb_regwen_d;
            wb_wsel_q   <= wb_wsel_d;
            wb_wdat_q   <= wb_wdat_d;
            wb_halt_q   <= wb_halt_d;
            wait_q      <= wait_d;
        end
    end

endmodule
